// File: rtl/game_pkg.sv
// Shared constants for the memory-game round controller:
// FSM encoding, verdict codes and LFSR taps.
package game_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHOW  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_OK   = 2'b01;
  localparam logic [1:0] RES_BAD  = 2'b10;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS    = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Player-facing bundle of the round controller:
// stimulus from the player/host, status back out.
interface game_round_ctrl_if;

  logic       start;
  logic [7:0] load;
  logic [7:0] x;
  logic       submit;
  logic [7:0] display;
  logic [1:0] result;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] state;
  logic       done;
  logic       win;

  modport master (
    output start, load, x, submit,
    input  display, result, score,
    input  lives, state, done, win
  );

  modport slave (
    input  start, load, x, submit,
    output display, result, score,
    output lives, state, done, win
  );

endinterface

// File: rtl/game_round_ctrl_lfsr8.sv
// 8-bit Fibonacci question generator; shifts left,
// feedback from taps 7,5,4,3 so it never locks at zero.
module lfsr8
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= seed;
    end else if (advance) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: shows a question for a set time,
// waits for a submit edge, scores it, tracks lives.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int         ROUNDS = 8,
  parameter int         LIVES  = 3,
  parameter logic [7:0] SEED   = DEFAULT_SEED
) (
  input logic         clk,
  input logic         reset,
  game_round_ctrl_if.slave bus
);

  localparam logic [7:0] ROUNDS_L = 8'(ROUNDS);
  localparam logic [1:0] LIVES_L  = 2'(LIVES);

  logic [2:0] r_state;
  logic [7:0] r_qn;
  logic [7:0] r_timer;
  logic [7:0] r_show_len;
  logic [7:0] r_ans;
  logic [7:0] r_round;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic [1:0] r_result;
  logic       r_sub_q;

  logic [7:0] w_lfsr;
  logic [7:0] w_load_eff;
  logic       w_start_ok;
  logic       w_sub_rise;
  logic       w_ok;
  logic [1:0] w_lives_nxt;
  logic [7:0] w_round_nxt;
  logic       w_end;
  logic       w_adv;

  assign w_load_eff = (bus.load == 8'd0)
                    ? 8'd1 : bus.load;
  assign w_start_ok = bus.start
                    && (r_state == S_IDLE
                     || r_state == S_DONE);
  assign w_sub_rise = bus.submit & ~r_sub_q;
  assign w_ok       = (r_ans == r_qn);
  assign w_lives_nxt = w_ok ? r_lives
                            : r_lives - 2'd1;
  assign w_round_nxt = r_round + 8'd1;
  assign w_end = (w_lives_nxt == 2'd0)
              || (w_round_nxt == ROUNDS_L);
  // LFSR steps exactly once per SHOW entry
  assign w_adv = w_start_ok
              || (r_state == S_CHECK && !w_end);

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (w_adv),
    .seed    (SEED),
    .q       (w_lfsr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_qn       <= 8'd0;
      r_timer    <= 8'd0;
      r_show_len <= 8'd1;
      r_ans      <= 8'd0;
      r_round    <= 8'd0;
      r_score    <= 8'd0;
      r_lives    <= 2'd0;
      r_result   <= RES_NONE;
      r_sub_q    <= 1'b0;
    end else begin
      r_sub_q <= bus.submit;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state    <= S_SHOW;
            r_qn       <= w_lfsr;
            r_timer    <= w_load_eff;
            r_show_len <= w_load_eff;
            r_score    <= 8'd0;
            r_lives    <= LIVES_L;
            r_round    <= 8'd0;
            r_result   <= RES_NONE;
          end
        end
        S_SHOW: begin
          if (r_timer <= 8'd1) begin
            r_state <= S_WAIT;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_WAIT: begin
          if (w_sub_rise) begin
            r_ans   <= bus.x;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_ok) begin
            r_result <= RES_OK;
            if (r_score != 8'hFF) begin
              r_score <= r_score + 8'd1;
            end
          end else begin
            r_result <= RES_BAD;
          end
          r_lives <= w_lives_nxt;
          r_round <= w_round_nxt;
          if (w_end) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_SHOW;
            r_qn    <= w_lfsr;
            r_timer <= r_show_len;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.display = (r_state == S_SHOW)
                     ? r_qn : 8'h00;
  assign bus.result  = r_result;
  assign bus.score   = r_score;
  assign bus.lives   = r_lives;
  assign bus.state   = r_state;
  assign bus.done    = (r_state == S_DONE);
  assign bus.win     = (r_state == S_DONE)
                    && (r_lives != 2'd0);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed-vector bench for game_round_ctrl: one
// default instance and one with ROUNDS=2.
module tb_game_round_ctrl;

  typedef struct {
    logic       start;
    logic [7:0] load;
    logic [7:0] x;
    logic       submit;
    logic [7:0] disp;
    logic [1:0] res;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] st;
    logic       done;
    logic       win;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  game_round_ctrl_if bus_a ();
  game_round_ctrl_if bus_b ();

  game_round_ctrl #(
    .ROUNDS (8),
    .LIVES  (3),
    .SEED   (8'hA5)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  game_round_ctrl #(
    .ROUNDS (2),
    .LIVES  (3),
    .SEED   (8'hA5)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  logic [24:0] w_a;
  logic [24:0] w_b;

  assign w_a = {bus_a.display, bus_a.result,
                bus_a.score, bus_a.lives,
                bus_a.state, bus_a.done, bus_a.win};
  assign w_b = {bus_b.display, bus_b.result,
                bus_b.score, bus_b.lives,
                bus_b.state, bus_b.done, bus_b.win};

  function automatic vec_t mk(
    input logic       s,
    input logic [7:0] ld,
    input logic [7:0] xx,
    input logic       sb,
    input logic [7:0] d,
    input logic [1:0] r,
    input logic [7:0] sc,
    input logic [1:0] lv,
    input logic [2:0] st,
    input logic       dn,
    input logic       w
  );
    vec_t v;
    v.start = s;  v.load = ld;
    v.x = xx;     v.submit = sb;
    v.disp = d;   v.res = r;
    v.score = sc; v.lives = lv;
    v.st = st;    v.done = dn;
    v.win = w;
    return v;
  endfunction

  function automatic logic [24:0] pk(input vec_t v);
    return {v.disp, v.res, v.score, v.lives,
            v.st, v.done, v.win};
  endfunction

  task automatic chk(
    input string       name,
    input logic [24:0] got,
    input logic [24:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h",
               name, got, exp);
    end
  endtask

  task automatic step(
    input vec_t  v,
    input bit    sel_b,
    input string name
  );
    if (sel_b) begin
      bus_b.start  = v.start;
      bus_b.load   = v.load;
      bus_b.x      = v.x;
      bus_b.submit = v.submit;
    end else begin
      bus_a.start  = v.start;
      bus_a.load   = v.load;
      bus_a.x      = v.x;
      bus_a.submit = v.submit;
    end
    @(posedge clk);
    #1;
    chk(name, sel_b ? w_b : w_a, pk(v));
  endtask

  vec_t ta[$];
  vec_t tb[$];
  vec_t v;

  initial begin
    reset = 1'b1;
    bus_a.start = 0; bus_a.load = 0;
    bus_a.x = 0;     bus_a.submit = 0;
    bus_b.start = 0; bus_b.load = 0;
    bus_b.x = 0;     bus_b.submit = 0;

    // start, load, x, submit | disp, res, score, lives, state, done, win
    ta.push_back(mk(1,3,8'h00,0, 8'hA5,0,0,3,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'hA5,0,0,3,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'hA5,0,0,3,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h00,0,0,3,2,0,0));
    ta.push_back(mk(0,3,8'hA5,1, 8'h00,0,0,3,3,0,0));
    ta.push_back(mk(0,3,8'hA5,1, 8'h4A,1,1,3,1,0,0));
    ta.push_back(mk(0,3,8'hA5,0, 8'h4A,1,1,3,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h4A,1,1,3,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h00,1,1,3,2,0,0));
    ta.push_back(mk(1,7,8'h00,0, 8'h00,1,1,3,2,0,0));
    ta.push_back(mk(0,3,8'h11,1, 8'h00,1,1,3,3,0,0));
    ta.push_back(mk(0,3,8'h11,0, 8'h95,2,1,2,1,0,0));
    ta.push_back(mk(1,9,8'h00,0, 8'h95,2,1,2,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h95,2,1,2,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h00,2,1,2,2,0,0));
    ta.push_back(mk(0,3,8'h00,1, 8'h00,2,1,2,3,0,0));
    ta.push_back(mk(1,3,8'h00,0, 8'h2A,2,1,1,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h2A,2,1,1,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h2A,2,1,1,1,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h00,2,1,1,2,0,0));
    ta.push_back(mk(0,3,8'h00,1, 8'h00,2,1,1,3,0,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h00,2,1,0,4,1,0));
    ta.push_back(mk(0,3,8'h00,0, 8'h00,2,1,0,4,1,0));
    ta.push_back(mk(1,0,8'h00,1, 8'h54,0,0,3,1,0,0));
    ta.push_back(mk(0,0,8'h00,1, 8'h00,0,0,3,2,0,0));
    ta.push_back(mk(0,0,8'h54,1, 8'h00,0,0,3,2,0,0));
    ta.push_back(mk(0,0,8'h54,0, 8'h00,0,0,3,2,0,0));
    ta.push_back(mk(0,0,8'h54,1, 8'h00,0,0,3,3,0,0));
    ta.push_back(mk(0,0,8'h54,0, 8'hA9,1,1,3,1,0,0));
    ta.push_back(mk(0,0,8'h00,0, 8'h00,1,1,3,2,0,0));

    tb.push_back(mk(1,2,8'h00,0, 8'hA5,0,0,3,1,0,0));
    tb.push_back(mk(1,5,8'h00,0, 8'hA5,0,0,3,1,0,0));
    tb.push_back(mk(0,2,8'h00,0, 8'h00,0,0,3,2,0,0));
    tb.push_back(mk(1,5,8'h00,0, 8'h00,0,0,3,2,0,0));
    tb.push_back(mk(0,2,8'hA5,1, 8'h00,0,0,3,3,0,0));
    tb.push_back(mk(0,2,8'hA5,0, 8'h4A,1,1,3,1,0,0));
    tb.push_back(mk(1,7,8'h00,0, 8'h4A,1,1,3,1,0,0));
    tb.push_back(mk(0,2,8'h00,0, 8'h00,1,1,3,2,0,0));
    tb.push_back(mk(0,2,8'h4A,1, 8'h00,1,1,3,3,0,0));
    tb.push_back(mk(0,2,8'h4A,0, 8'h00,1,2,3,4,1,1));
    tb.push_back(mk(0,2,8'h00,0, 8'h00,1,2,3,4,1,1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", w_a, 25'd0);
    chk("reset_b", w_b, 25'd0);
    reset = 1'b0;

    foreach (ta[i]) begin
      step(ta[i], 1'b0, $sformatf("a_vec%0d", i));
    end

    // reset lands between edges while waiting for an answer
    #2;
    reset = 1'b1;
    #1;
    chk("reset_mid_wait", w_a, 25'd0);
    @(posedge clk);
    #1;
    chk("reset_held", w_a, 25'd0);
    reset = 1'b0;

    v = mk(1,2,8'h00,0, 8'hA5,0,0,3,1,0,0);
    step(v, 1'b0, "reseed_show1");
    v = mk(0,2,8'h00,0, 8'hA5,0,0,3,1,0,0);
    step(v, 1'b0, "reseed_show2");
    v = mk(0,2,8'h00,0, 8'h00,0,0,3,2,0,0);
    step(v, 1'b0, "reseed_wait");

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (tb[i]) begin
      step(tb[i], 1'b1, $sformatf("b_vec%0d", i));
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 8: number of rounds per game (1..255).
REQ-002 Parameter LIVES, default 3: wrong answers allowed before game over (1..3).
REQ-003 Parameter SEED, default 8'hA5: LFSR reset value; nonzero.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begins a game; honoured only in IDLE or DONE.
REQ-007 load  in  8  show time in cycles, sampled on accepted start.
REQ-008 x  in  8  player answer.
REQ-009 submit  in  1  answer strobe; a rising edge counts, level does not.
REQ-010 display  out  8  current question during SHOW, else 8'h00.
REQ-011 result  out  2  last verdict: 00 none, 01 correct, 10 wrong.
REQ-012 score  out  8  correct answers this game.
REQ-013 lives  out  2  remaining lives.
REQ-014 state  out  3  FSM state: IDLE=0, SHOW=1, WAIT=2, CHECK=3, DONE=4.
REQ-015 done  out  1  high while in DONE.
REQ-016 win  out  1  valid in DONE; 1 = all ROUNDS played with lives>0.

Function
REQ-017 Question source: 8-bit Fibonacci LFSR, shift left, new bit0 = b7^b5^b4^b3; never reaches zero.
REQ-018 On entry to SHOW: qn <= lfsr; lfsr advances once; timer <= load, with load=0 treated as 1.
REQ-019 IDLE/DONE + start -> SHOW next cycle; score cleared, lives <= LIVES, round <= 0, result <= 00, show time latched.
REQ-020 SHOW: display = qn for exactly the latched number of cycles, then -> WAIT.
REQ-021 WAIT: display = 00; a submit rising edge (submit & ~submit_q) captures x and -> CHECK.
REQ-022 Submit edges outside WAIT are ignored; submit_q is tracked in every state, so a level held from SHOW into WAIT does not capture.
REQ-023 CHECK (one cycle): x == qn -> score+1 (saturates at 255), result <= 01; else lives-1, result <= 10; round+1.
REQ-024 After CHECK: lives == 0 or round == ROUNDS -> DONE; otherwise -> SHOW, starting the next round with no idle cycle.
REQ-025 result holds its value until the next CHECK or accepted start.
REQ-026 DONE: win = (lives != 0); outputs hold; start restarts the game; the LFSR is not reseeded.
REQ-027 start is ignored in SHOW, WAIT and CHECK.

Reset
REQ-028 Asserting reset at any time, including mid-round, immediately forces IDLE and display=00, result=00, score=0, lives=0, done=0, win=0, lfsr=SEED, submit_q=0.
REQ-029 After release, the first accepted start produces the question SEED.

Structure
REQ-030 Shared package game_pkg holds the state encoding, result codes (RES_NONE, RES_OK, RES_BAD), the default SEED, and the LFSR tap constants.
REQ-031 The LFSR is a sub-module lfsr8 with ports clk, reset, advance, seed, and q; the FSM, timer, counters and edge detector stay in game_round_ctrl.

Verification
REQ-032 reset, load=3, start pulse -> SHOW next cycle; display=A5 for exactly 3 cycles, then 00; state=WAIT.
REQ-033 In WAIT, x=A5 with a submit rise -> CHECK for 1 cycle; result=01, score=1; next SHOW displays 4A.
REQ-034 LIVES=3, three wrong submits -> lives 3,2,1,0; result=10; done=1, win=0; start then restarts with lives=3, score=0.
REQ-035 load=0 -> display is nonzero for exactly 1 cycle; submit held high from SHOW into WAIT -> no capture until it is released and reasserted.
REQ-036 ROUNDS=2, two correct answers -> done=1, win=1, score=2; start pulses during SHOW/WAIT are ignored (no state change).
REQ-037 reset asserted in WAIT between clock edges -> outputs reach reset values before the next edge; state=IDLE.
